// File: rtl/brick_sequencer.sv
// Round controller for the three-brick game: steps the moving brick on divided ticks,
// freezes it on stop, checks alignment, and drives the aligne pulse and perdu level.
module brick_sequencer #(
  parameter int NPOS     = 8,
  parameter int POS_W    = 3,
  parameter int LIVES    = 3,
  parameter int DIV_INIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  output logic [POS_W-1:0] pos0,
  output logic [POS_W-1:0] pos1,
  output logic [POS_W-1:0] pos2,
  output logic [1:0]       moving,
  output logic [1:0]       lives,
  output logic             aligne,
  output logic             perdu
);

  typedef enum logic [2:0] {IDLE, RUN0, RUN1, RUN2, CHECK, LOST} state_t;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NPOS - 1);
  localparam logic [3:0]       DIV0    = 4'(DIV_INIT);
  localparam logic [1:0]       LIVES0  = 2'(LIVES);

  state_t           state, state_nx;
  logic [POS_W-1:0] pos_q  [3];
  logic [POS_W-1:0] pos_nx [3];
  logic [1:0]       lives_q, lives_nx;
  logic             aligne_q, aligne_nx;
  logic [3:0]       div_q, div_nx;
  logic [3:0]       divcnt_q, divcnt_nx;
  logic [1:0]       run_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pos_q[0] <= '0;
      pos_q[1] <= '0;
      pos_q[2] <= '0;
      lives_q  <= LIVES0;
      aligne_q <= 1'b0;
      div_q    <= DIV0;
      divcnt_q <= 4'd0;
    end else begin
      state    <= state_nx;
      pos_q[0] <= pos_nx[0];
      pos_q[1] <= pos_nx[1];
      pos_q[2] <= pos_nx[2];
      lives_q  <= lives_nx;
      aligne_q <= aligne_nx;
      div_q    <= div_nx;
      divcnt_q <= divcnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pos_nx[0] = pos_q[0];
    pos_nx[1] = pos_q[1];
    pos_nx[2] = pos_q[2];
    lives_nx  = lives_q;
    aligne_nx = 1'b0;
    div_nx    = div_q;
    divcnt_nx = divcnt_q;
    run_idx   = 2'd0;
    if (state == RUN1) run_idx = 2'd1;
    if (state == RUN2) run_idx = 2'd2;

    case (state)
      IDLE, LOST: begin
        if (start) begin
          state_nx  = RUN0;
          lives_nx  = LIVES0;
          div_nx    = DIV0;
          divcnt_nx = 4'd0;
          pos_nx[0] = '0;
          pos_nx[1] = '0;
          pos_nx[2] = '0;
        end
      end
      RUN0, RUN1, RUN2: begin
        // stop has priority over a coincident tick, so the brick freezes where it shows
        if (stop) begin
          divcnt_nx = 4'd0;
          case (state)
            RUN0:    state_nx = RUN1;
            RUN1:    state_nx = RUN2;
            default: state_nx = CHECK;
          endcase
        end else if (tick) begin
          if (divcnt_q == div_q - 4'd1) begin
            divcnt_nx        = 4'd0;
            pos_nx[run_idx]  = (pos_q[run_idx] == POS_MAX) ? '0 : pos_q[run_idx] + 1'b1;
          end else begin
            divcnt_nx = divcnt_q + 4'd1;
          end
        end
      end
      CHECK: begin
        if (pos_q[0] == pos_q[1] && pos_q[1] == pos_q[2]) begin
          aligne_nx = 1'b1;
          div_nx    = (div_q > 4'd1) ? div_q - 4'd1 : 4'd1;
          state_nx  = RUN0;
        end else begin
          lives_nx = lives_q - 2'd1;
          state_nx = (lives_q == 2'd1) ? LOST : RUN0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      RUN0:    moving = 2'd0;
      RUN1:    moving = 2'd1;
      RUN2:    moving = 2'd2;
      default: moving = 2'd3;
    endcase
  end

  assign pos0   = pos_q[0];
  assign pos1   = pos_q[1];
  assign pos2   = pos_q[2];
  assign lives  = lives_q;
  assign aligne = aligne_q;
  assign perdu  = (state == LOST);

endmodule

// File: tb/tb_brick_sequencer.sv
// Directed self-checking bench for brick_sequencer with hand-computed expectations.
module tb_brick_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] pos0, pos1, pos2;
  logic [1:0] moving, lives;
  logic       aligne, perdu;

  int errors = 0;
  int checks = 0;

  brick_sequencer #(.NPOS(8), .POS_W(3), .LIVES(3), .DIV_INIT(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .pos0(pos0), .pos1(pos1), .pos2(pos2), .moving(moving), .lives(lives),
    .aligne(aligne), .perdu(perdu)
  );

  always #5 clk = ~clk;

  // inputs change 1 time unit after a rising edge; outputs are sampled there too
  task automatic cycle(input logic t, input logic s, input logic st);
    tick = t; stop = s; start = st;
    @(posedge clk); #1;
    tick = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic fresh_game();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (pos0 !== 3'd0 || pos1 !== 3'd0 || pos2 !== 3'd0) begin errors++; $display("FAIL reset_pos got %0d %0d %0d want 0 0 0", pos0, pos1, pos2); end
    checks++; if (moving !== 2'd3) begin errors++; $display("FAIL reset_moving got %0d want 3", moving); end
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", lives); end
    checks++; if (aligne !== 1'b0 || perdu !== 1'b0) begin errors++; $display("FAIL reset_flags got aligne=%0b perdu=%0b want 0 0", aligne, perdu); end
    reset = 1'b0;
    cycle(1'b1, 1'b1, 1'b0);
    checks++; if (moving !== 2'd3 || pos0 !== 3'd0) begin errors++; $display("FAIL idle_ignores got moving=%0d pos0=%0d want 3 0", moving, pos0); end
  endtask

  task automatic test_stepping();
    fresh_game();
    checks++; if (moving !== 2'd0 || pos0 !== 3'd0) begin errors++; $display("FAIL start_run0 got moving=%0d pos0=%0d want 0 0", moving, pos0); end
    ticks(3);
    checks++; if (pos0 !== 3'd0) begin errors++; $display("FAIL step_3ticks got %0d want 0", pos0); end
    ticks(1);
    checks++; if (pos0 !== 3'd1) begin errors++; $display("FAIL step_4ticks got %0d want 1", pos0); end
    ticks(24);
    checks++; if (pos0 !== 3'd7) begin errors++; $display("FAIL step_28ticks got %0d want 7", pos0); end
    ticks(4);
    checks++; if (pos0 !== 3'd0 || pos1 !== 3'd0) begin errors++; $display("FAIL wrap_32ticks got pos0=%0d pos1=%0d want 0 0", pos0, pos1); end
  endtask

  task automatic test_aligned();
    fresh_game();
    ticks(12); cycle(1'b0, 1'b1, 1'b0);
    checks++; if (pos0 !== 3'd3 || moving !== 2'd1) begin errors++; $display("FAIL al_stop0 got pos0=%0d moving=%0d want 3 1", pos0, moving); end
    ticks(12); cycle(1'b0, 1'b1, 1'b0);
    ticks(12); cycle(1'b0, 1'b1, 1'b0);
    checks++; if (moving !== 2'd3 || aligne !== 1'b0 || pos2 !== 3'd3) begin errors++; $display("FAIL al_check got moving=%0d aligne=%0b pos2=%0d want 3 0 3", moving, aligne, pos2); end
    cycle(1'b0, 1'b0, 1'b0);
    checks++; if (aligne !== 1'b1 || moving !== 2'd0 || lives !== 2'd3) begin errors++; $display("FAIL al_pulse got aligne=%0b moving=%0d lives=%0d want 1 0 3", aligne, moving, lives); end
    ticks(2);
    checks++; if (aligne !== 1'b0 || pos0 !== 3'd3) begin errors++; $display("FAIL al_pulse_end got aligne=%0b pos0=%0d want 0 3", aligne, pos0); end
    ticks(1);
    checks++; if (pos0 !== 3'd4) begin errors++; $display("FAIL al_div3 got pos0=%0d want 4", pos0); end
  endtask

  task automatic test_lose();
    fresh_game();
    ticks(12); cycle(1'b0, 1'b1, 1'b0);
    ticks(12); cycle(1'b0, 1'b1, 1'b0);
    ticks(20); cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    checks++; if (lives !== 2'd2 || aligne !== 1'b0 || moving !== 2'd0) begin errors++; $display("FAIL lose_r1 got lives=%0d aligne=%0b moving=%0d want 2 0 0", lives, aligne, moving); end
    for (int r = 0; r < 2; r++) begin
      cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    checks++; if (lives !== 2'd0 || perdu !== 1'b1 || moving !== 2'd3) begin errors++; $display("FAIL lose_final got lives=%0d perdu=%0b moving=%0d want 0 1 3", lives, perdu, moving); end
    cycle(1'b1, 1'b1, 1'b0); ticks(5); cycle(1'b0, 1'b1, 1'b0);
    checks++; if (perdu !== 1'b1 || lives !== 2'd0 || aligne !== 1'b0) begin errors++; $display("FAIL lost_hold got perdu=%0b lives=%0d aligne=%0b want 1 0 0", perdu, lives, aligne); end
    checks++; if (pos0 !== 3'd3 || pos1 !== 3'd3 || pos2 !== 3'd5) begin errors++; $display("FAIL lost_frozen got %0d %0d %0d want 3 3 5", pos0, pos1, pos2); end
    cycle(1'b0, 1'b0, 1'b1);
    checks++; if (perdu !== 1'b0 || lives !== 2'd3 || moving !== 2'd0 || pos2 !== 3'd0) begin errors++; $display("FAIL restart got perdu=%0b lives=%0d moving=%0d pos2=%0d want 0 3 0 0", perdu, lives, moving, pos2); end
  endtask

  task automatic test_stop_tick();
    fresh_game();
    ticks(3);
    cycle(1'b1, 1'b1, 1'b0);
    checks++; if (pos0 !== 3'd0 || moving !== 2'd1) begin errors++; $display("FAIL stop_wins got pos0=%0d moving=%0d want 0 1", pos0, moving); end
    ticks(4);
    checks++; if (pos1 !== 3'd1 || pos0 !== 3'd0) begin errors++; $display("FAIL next_brick got pos1=%0d pos0=%0d want 1 0", pos1, pos0); end
    cycle(1'b0, 1'b0, 1'b1);
    checks++; if (moving !== 2'd1 || pos1 !== 3'd1) begin errors++; $display("FAIL start_ignored got moving=%0d pos1=%0d want 1 1", moving, pos1); end
  endtask

  task automatic test_div_saturate();
    int pulses = 0;
    fresh_game();
    for (int r = 0; r < 5; r++) begin
      cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      if (aligne === 1'b1) pulses++;
    end
    checks++; if (pulses !== 5) begin errors++; $display("FAIL sat_pulses got %0d want 5", pulses); end
    ticks(1);
    checks++; if (pos0 !== 3'd1 || aligne !== 1'b0) begin errors++; $display("FAIL sat_step1 got pos0=%0d aligne=%0b want 1 0", pos0, aligne); end
    ticks(1);
    checks++; if (pos0 !== 3'd2) begin errors++; $display("FAIL sat_step2 got pos0=%0d want 2", pos0); end
  endtask

  task automatic test_async_reset();
    fresh_game();
    ticks(8); cycle(1'b0, 1'b1, 1'b0);
    ticks(4);
    checks++; if (moving !== 2'd1 || pos0 !== 3'd2 || pos1 !== 3'd1) begin errors++; $display("FAIL pre_reset got moving=%0d pos0=%0d pos1=%0d want 1 2 1", moving, pos0, pos1); end
    #2 reset = 1'b1;
    #1;
    checks++; if (moving !== 2'd3 || pos0 !== 3'd0 || pos1 !== 3'd0 || pos2 !== 3'd0) begin errors++; $display("FAIL async_reset got moving=%0d pos=%0d %0d %0d want 3 0 0 0", moving, pos0, pos1, pos2); end
    checks++; if (lives !== 2'd3 || aligne !== 1'b0 || perdu !== 1'b0) begin errors++; $display("FAIL async_flags got lives=%0d aligne=%0b perdu=%0b want 3 0 0", lives, aligne, perdu); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stepping();
    test_aligned();
    test_lose();
    test_stop_tick();
    test_div_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
